// File: rtl/tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tx_arbiter
//  Description : Round-robin arbiter that lets NUM_REQ byte sources share one
//                UART TX FIFO. A grant is held for a whole message (until a
//                byte flagged last is written) or until the owner has had no
//                valid data for IDLE_TIMEOUT consecutive cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      wr_req,
  output logic [DATA_W-1:0]         wr_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
);

  localparam int                C_PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [C_PTR_W:0]  C_NUM        = (C_PTR_W+1)'(NUM_REQ);
  localparam logic [C_PTR_W-1:0] C_LAST_IDX  = C_PTR_W'(NUM_REQ - 1);
  localparam logic [15:0]       C_TIMEOUT_M1 = 16'(IDLE_TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic [C_PTR_W-1:0]   r_gidx, w_gidx_nxt;
  logic [C_PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [15:0]          r_idle_cnt, w_idle_cnt_nxt;

  logic [C_PTR_W:0]     w_cand;
  logic [C_PTR_W-1:0]   w_arb_idx;
  logic                 w_arb_hit;
  logic [C_PTR_W-1:0]   w_gidx_inc;
  logic                 w_valid_g;
  logic                 w_last_g;
  logic [DATA_W-1:0]    w_data_g;
  logic                 w_own;
  logic                 w_xfer;

  // Round-robin search: first valid requester at or above the pointer, with wrap.
  always_comb begin
    w_cand    = '0;
    w_arb_idx = r_ptr;
    w_arb_hit = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_ptr} + (C_PTR_W+1)'(k);
      if (w_cand >= C_NUM) begin
        w_cand = w_cand - C_NUM;
      end
      if (!w_arb_hit && req_valid[w_cand[C_PTR_W-1:0]]) begin
        w_arb_hit = 1'b1;
        w_arb_idx = w_cand[C_PTR_W-1:0];
      end
    end
  end

  // Route the owner's valid/last/data onto a single set of wires.
  always_comb begin
    w_valid_g = 1'b0;
    w_last_g  = 1'b0;
    w_data_g  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gidx == C_PTR_W'(i)) begin
        w_valid_g = req_valid[i];
        w_last_g  = req_last[i];
        w_data_g  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_gidx_inc = (r_gidx == C_LAST_IDX) ? '0 : r_gidx + 1'b1;

  // Reset gates the handshake outputs immediately, even mid-message.
  assign w_own     = (r_state == S_OWN) && !rst;
  assign w_xfer    = w_own && w_valid_g && !fifo_full;
  assign wr_req    = w_xfer;
  assign wr_data   = w_data_g;
  assign req_ready = (w_own && !fifo_full) ? r_grant : '0;
  assign grant     = rst ? '0 : r_grant;
  assign busy      = |grant;

  // Next-state logic: arbitrate in IDLE, release on last byte or idle timeout.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_gidx_nxt     = r_gidx;
    w_ptr_nxt      = r_ptr;
    w_idle_cnt_nxt = r_idle_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_arb_hit) begin
          w_state_nxt    = S_OWN;
          w_grant_nxt    = NUM_REQ'(1) << w_arb_idx;
          w_gidx_nxt     = w_arb_idx;
          w_idle_cnt_nxt = '0;
        end
      end
      S_OWN: begin
        if (w_xfer) begin
          w_idle_cnt_nxt = '0;
          if (w_last_g) begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_ptr_nxt   = w_gidx_inc;
          end
        end else if (!w_valid_g) begin
          // The cycle that brings the count to IDLE_TIMEOUT releases the grant,
          // so the counter never has to advance past its limit.
          if (r_idle_cnt >= C_TIMEOUT_M1) begin
            w_state_nxt    = S_IDLE;
            w_grant_nxt    = '0;
            w_ptr_nxt      = w_gidx_inc;
            w_idle_cnt_nxt = '0;
          end else begin
            w_idle_cnt_nxt = r_idle_cnt + 16'd1;
          end
        end
        // Valid but stalled by fifo_full: hold everything, counter untouched.
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State, grant, pointer and idle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_ptr      <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_gidx     <= w_gidx_nxt;
      r_ptr      <= w_ptr_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_arbiter
//  Description : Directed, table-driven bench for tx_arbiter (4 requesters,
//                8-bit data, IDLE_TIMEOUT=4) plus hand sequences for
//                long backpressure and reset in the middle of a message.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        wr_req;
  logic [7:0]  wr_data;
  logic [3:0]  grant;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  tx_arbiter #(
    .NUM_REQ     (4),
    .DATA_W      (8),
    .IDLE_TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .fifo_full(fifo_full),
    .wr_req   (wr_req),
    .wr_data  (wr_data),
    .grant    (grant),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        full;
    logic [31:0] data;
    logic [3:0]  e_grant;
    logic        e_wr;
    logic [7:0]  e_wdata;
    logic [3:0]  e_ready;
  } vec_t;

  vec_t vq[$];

  localparam logic [31:0] D = 32'hA3A2A1A0;

  task automatic addv(input logic r, input logic [3:0] v, input logic [3:0] l,
                      input logic f, input logic [31:0] d, input logic [3:0] g,
                      input logic w, input logic [7:0] wd, input logic [3:0] rdy);
    vec_t t;
    t.rst = r; t.valid = v; t.last = l; t.full = f; t.data = d;
    t.e_grant = g; t.e_wr = w; t.e_wdata = wd; t.e_ready = rdy;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                       input logic f, input logic [31:0] d);
    rst = r; req_valid = v; req_last = l; fifo_full = f; req_data = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 4'b0, 4'b0, 1'b0, D);

    // rst valid last  full data         grant  wr  wdata  ready
    addv(1, 4'b0000, 4'b0000, 0, D,            4'b0000, 0, 8'h00, 4'b0000); // 0 reset
    addv(1, 4'b0010, 4'b0000, 0, D,            4'b0000, 0, 8'h00, 4'b0000); // 1 reset beats request
    addv(0, 4'b0010, 4'b0000, 0, 32'hA3A248A0, 4'b0000, 0, 8'h00, 4'b0000); // 2 arbitrate
    addv(0, 4'b0010, 4'b0000, 0, 32'hA3A248A0, 4'b0010, 1, 8'h48, 4'b0010); // 3 'H'
    addv(0, 4'b0010, 4'b0010, 0, 32'hA3A269A0, 4'b0010, 1, 8'h69, 4'b0010); // 4 'i' last
    addv(0, 4'b0000, 4'b0000, 0, D,            4'b0000, 0, 8'h00, 4'b0000); // 5 released
    addv(1, 4'b0000, 4'b0000, 0, D,            4'b0000, 0, 8'h00, 4'b0000); // 6 reset ptr
    addv(0, 4'b1111, 4'b1111, 0, D,            4'b0000, 0, 8'h00, 4'b0000); // 7 round robin
    addv(0, 4'b1111, 4'b1111, 0, D,            4'b0001, 1, 8'hA0, 4'b0001); // 8
    addv(0, 4'b1111, 4'b1111, 0, D,            4'b0000, 0, 8'h00, 4'b0000); // 9
    addv(0, 4'b1111, 4'b1111, 0, D,            4'b0010, 1, 8'hA1, 4'b0010); // 10
    addv(0, 4'b1111, 4'b1111, 0, D,            4'b0000, 0, 8'h00, 4'b0000); // 11
    addv(0, 4'b1111, 4'b1111, 0, D,            4'b0100, 1, 8'hA2, 4'b0100); // 12
    addv(0, 4'b1111, 4'b1111, 0, D,            4'b0000, 0, 8'h00, 4'b0000); // 13
    addv(0, 4'b1111, 4'b1111, 0, D,            4'b1000, 1, 8'hA3, 4'b1000); // 14
    addv(0, 4'b1111, 4'b1111, 0, D,            4'b0000, 0, 8'h00, 4'b0000); // 15
    addv(0, 4'b1111, 4'b1111, 0, D,            4'b0001, 1, 8'hA0, 4'b0001); // 16 wrap to 0
    addv(0, 4'b0000, 4'b0000, 0, D,            4'b0000, 0, 8'h00, 4'b0000); // 17
    addv(0, 4'b1000, 4'b0000, 0, 32'h30A2A1A0, 4'b0000, 0, 8'h00, 4'b0000); // 18 req 3
    addv(0, 4'b1001, 4'b0000, 0, 32'h31A2A1A0, 4'b1000, 1, 8'h31, 4'b1000); // 19 no preempt
    addv(0, 4'b1001, 4'b0000, 1, 32'h32A2A1A0, 4'b1000, 0, 8'h00, 4'b0000); // 20 stalled
    addv(0, 4'b1001, 4'b1000, 0, 32'h32A2A1A0, 4'b1000, 1, 8'h32, 4'b1000); // 21 last
    addv(0, 4'b0001, 4'b0000, 0, 32'hA3A2A155, 4'b0000, 0, 8'h00, 4'b0000); // 22 req 0
    addv(0, 4'b0001, 4'b0000, 0, 32'hA3A2A155, 4'b0001, 1, 8'h55, 4'b0001); // 23 one byte
    addv(0, 4'b0000, 4'b0000, 0, D,            4'b0001, 0, 8'h00, 4'b0001); // 24 idle 1
    addv(0, 4'b0000, 4'b0000, 0, D,            4'b0001, 0, 8'h00, 4'b0001); // 25 idle 2
    addv(0, 4'b0000, 4'b0000, 0, D,            4'b0001, 0, 8'h00, 4'b0001); // 26 idle 3
    addv(0, 4'b0000, 4'b0000, 0, D,            4'b0001, 0, 8'h00, 4'b0001); // 27 idle 4
    addv(0, 4'b0000, 4'b0000, 0, D,            4'b0000, 0, 8'h00, 4'b0000); // 28 timed out
    addv(0, 4'b0011, 4'b0010, 0, D,            4'b0000, 0, 8'h00, 4'b0000); // 29 ptr now 1
    addv(0, 4'b0011, 4'b0010, 0, D,            4'b0010, 1, 8'hA1, 4'b0010); // 30
    addv(0, 4'b0000, 4'b0000, 0, D,            4'b0000, 0, 8'h00, 4'b0000); // 31

    @(posedge clk);
    #1;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].valid, vq[i].last, vq[i].full, vq[i].data);
      #1;
      chk("grant", i, 32'(grant), 32'(vq[i].e_grant));
      chk("busy", i, 32'(busy), 32'(|vq[i].e_grant));
      chk("wr_req", i, 32'(wr_req), 32'(vq[i].e_wr));
      chk("req_ready", i, 32'(req_ready), 32'(vq[i].e_ready));
      if (vq[i].e_wr) begin
        chk("wr_data", i, 32'(wr_data), 32'(vq[i].e_wdata));
      end
      next_cycle();
    end

    // Long backpressure on requester 2 (pointer is at 2 here).
    drive(1'b0, 4'b0100, 4'b0000, 1'b0, 32'hA377A1A0);
    #1;
    chk("bp_arb_grant", 0, 32'(grant), 32'h0);
    next_cycle();
    fifo_full = 1'b1;
    for (int c = 0; c < 300; c++) begin
      #1;
      chk("bp_wr_req", c, 32'(wr_req), 32'h0);
      chk("bp_grant", c, 32'(grant), 32'h4);
      chk("bp_ready", c, 32'(req_ready), 32'h0);
      next_cycle();
    end
    fifo_full = 1'b0;
    req_last  = 4'b0100;
    #1;
    chk("bp_resume_wr", 0, 32'(wr_req), 32'h1);
    chk("bp_resume_data", 0, 32'(wr_data), 32'h77);
    chk("bp_resume_ready", 0, 32'(req_ready), 32'h4);
    next_cycle();
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, D);
    #1;
    chk("bp_release", 0, 32'(grant), 32'h0);
    next_cycle();

    // Reset pulse during requester 1's second byte.
    drive(1'b0, 4'b0010, 4'b0000, 1'b0, 32'hA3A211A0);
    #1;
    chk("rm_arb_grant", 0, 32'(grant), 32'h0);
    next_cycle();
    #1;
    chk("rm_byte1_wr", 0, 32'(wr_req), 32'h1);
    chk("rm_byte1_data", 0, 32'(wr_data), 32'h11);
    next_cycle();
    drive(1'b1, 4'b0010, 4'b0000, 1'b0, 32'hA3A222A0);
    #1;
    chk("rm_rst_wr", 0, 32'(wr_req), 32'h0);
    chk("rm_rst_grant", 0, 32'(grant), 32'h0);
    chk("rm_rst_ready", 0, 32'(req_ready), 32'h0);
    chk("rm_rst_busy", 0, 32'(busy), 32'h0);
    next_cycle();
    drive(1'b0, 4'b0110, 4'b0000, 1'b0, 32'hA3BB22A0);
    #1;
    chk("rm_idle_grant", 0, 32'(grant), 32'h0);
    next_cycle();
    #1;
    chk("rm_regrant", 0, 32'(grant), 32'h2);
    chk("rm_regrant_wr", 0, 32'(wr_req), 32'h1);
    chk("rm_regrant_data", 0, 32'(wr_data), 32'h22);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
